// File: rtl/tl_ul_reg_bridge_pkg.sv
// Shared TileLink-UL definitions: opcodes, D-channel param width and the
// bridge FSM state type.
package tl_ul_reg_bridge_pkg;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam int D_PARAM_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  // A request reaches the register side only for a supported opcode with a
  // single-beat size that is naturally aligned.
  function automatic logic req_legal(input logic [2:0] opcode,
                                     input logic [2:0] size,
                                     input logic [1:0] addr_lsb);
    logic op_ok;
    logic align_ok;
    op_ok = (opcode == TL_PUT_FULL) || (opcode == TL_PUT_PARTIAL) ||
            (opcode == TL_GET);
    case (size)
      3'd0:    align_ok = 1'b1;
      3'd1:    align_ok = (addr_lsb[0] == 1'b0);
      3'd2:    align_ok = (addr_lsb == 2'b00);
      default: align_ok = 1'b0;
    endcase
    return op_ok && align_ok;
  endfunction

endpackage

// File: rtl/tl_ul_reg_bridge.sv
// TL-UL slave to simple register-bus bridge: one outstanding transaction,
// denied responses for unsupported requests and register-side timeouts.
module tl_ul_reg_bridge
  import tl_ul_reg_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [2:0]           a_opcode,
  input  logic [2:0]           a_param,
  input  logic [2:0]           a_size,
  input  logic [SRC_W-1:0]     a_source,
  input  logic [ADDR_W-1:0]    a_address,
  input  logic [3:0]           a_mask,
  input  logic [31:0]          a_data,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic [2:0]           d_opcode,
  output logic [D_PARAM_W-1:0] d_param,
  output logic [2:0]           d_size,
  output logic [SRC_W-1:0]     d_source,
  output logic [31:0]          d_data,
  output logic                 d_denied,
  output logic                 d_corrupt,
  output logic                 reg_req,
  output logic                 reg_we,
  output logic [ADDR_W-1:0]    reg_addr,
  output logic [3:0]           reg_be,
  output logic [31:0]          reg_wdata,
  input  logic                 reg_ack,
  input  logic [31:0]          reg_rdata,
  input  logic                 reg_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                run_reg;
  logic [2:0]          op_reg, op_next;
  logic [2:0]          size_reg, size_next;
  logic [SRC_W-1:0]    source_reg, source_next;
  logic [ADDR_W-1:2]   addr_reg, addr_next;
  logic [3:0]          mask_reg, mask_next;
  logic [31:0]         data_reg, data_next;
  logic [31:0]         rdata_reg, rdata_next;
  logic                denied_reg, denied_next;
  logic                is_get;
  logic                unused_param;

  // TL-UL carries no meaningful A-channel param for these opcodes.
  assign unused_param = ^a_param;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      run_reg    <= 1'b0;
      op_reg     <= '0;
      size_reg   <= '0;
      source_reg <= '0;
      addr_reg   <= '0;
      mask_reg   <= '0;
      data_reg   <= '0;
      rdata_reg  <= '0;
      denied_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      run_reg    <= 1'b1;
      op_reg     <= op_next;
      size_reg   <= size_next;
      source_reg <= source_next;
      addr_reg   <= addr_next;
      mask_reg   <= mask_next;
      data_reg   <= data_next;
      rdata_reg  <= rdata_next;
      denied_reg <= denied_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    size_next   = size_reg;
    source_next = source_reg;
    addr_next   = addr_reg;
    mask_next   = mask_reg;
    data_next   = data_reg;
    rdata_next  = rdata_reg;
    denied_next = denied_reg;
    case (state_reg)
      ST_IDLE: begin
        if (a_valid && a_ready) begin
          op_next     = a_opcode;
          size_next   = a_size;
          source_next = a_source;
          addr_next   = a_address[ADDR_W-1:2];
          mask_next   = a_mask;
          data_next   = a_data;
          rdata_next  = '0;
          cnt_next    = '0;
          if (req_legal(a_opcode, a_size, a_address[1:0])) begin
            denied_next = 1'b0;
            state_next  = ST_ACCESS;
          end else begin
            denied_next = 1'b1;
            state_next  = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        // An acknowledge in the final allowed cycle takes priority over timeout.
        if (reg_ack) begin
          rdata_next  = reg_rdata;
          denied_next = reg_err;
          cnt_next    = '0;
          state_next  = ST_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          denied_next = 1'b1;
          cnt_next    = '0;
          state_next  = ST_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (d_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign is_get = (op_reg == TL_GET);

  assign a_ready   = run_reg && (state_reg == ST_IDLE);
  assign reg_req   = (state_reg == ST_ACCESS);
  assign reg_we    = reg_req && !is_get;
  assign reg_addr  = {addr_reg, 2'b00};
  assign reg_be    = is_get ? 4'hF : mask_reg;
  assign reg_wdata = data_reg;

  assign d_valid   = (state_reg == ST_RESP);
  assign d_opcode  = is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
  assign d_param   = '0;
  assign d_size    = size_reg;
  assign d_source  = source_reg;
  assign d_denied  = denied_reg;
  assign d_corrupt = denied_reg && is_get;
  assign d_data    = (is_get && !denied_reg) ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_tl_ul_reg_bridge.sv
// Bench for tl_ul_reg_bridge: directed vector table, reset sequences and
// randomized transactions against a request-level reference model.
module tb_tl_ul_reg_bridge;

  localparam int ADDR_W  = 32;
  localparam int SRC_W   = 2;
  localparam int TIMEOUT = 4;

  logic              clock;
  logic              reset_n;
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic [31:0]       d_data;
  logic              d_denied;
  logic              d_corrupt;
  logic              reg_req;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [3:0]        reg_be;
  logic [31:0]       reg_wdata;
  logic              reg_ack;
  logic [31:0]       reg_rdata;
  logic              reg_err;

  int checks = 0;
  int errors = 0;

  tl_ul_reg_bridge #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_data(d_data), .d_denied(d_denied),
    .d_corrupt(d_corrupt),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_be(reg_be),
    .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    int          ack_delay;  // ACCESS cycle index of reg_ack, -1 = never
    logic [31:0] rdata;
    logic        err;
    int          dr_delay;   // cycles d_ready stays low in RESP
    logic [2:0]  exp_dop;
    logic        exp_den;
    logic [31:0] exp_data;
    int          exp_reqcyc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of one request derived from the protocol rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit legal, timed_out;
    r = v;
    legal = (v.opcode == 0 || v.opcode == 1 || v.opcode == 4) && v.size <= 2 &&
            (v.addr % (32'd1 << v.size)) == 0;
    timed_out = (v.ack_delay < 0) || (v.ack_delay >= TIMEOUT);
    r.exp_dop = (v.opcode == 4) ? 3'd1 : 3'd0;
    r.exp_den = !legal || timed_out || v.err;
    r.exp_data = (v.opcode == 4 && !r.exp_den) ? v.rdata : 32'h0;
    r.exp_reqcyc = !legal ? 0 : (timed_out ? TIMEOUT : v.ack_delay + 1);
    return r;
  endfunction

  task automatic check_d(input vec_t v, input string tag);
    chk({tag, "_d_valid"}, d_valid, 1'b1);
    chk({tag, "_d_opcode"}, d_opcode, v.exp_dop);
    chk({tag, "_d_param"}, d_param, 2'd0);
    chk({tag, "_d_size"}, d_size, v.size);
    chk({tag, "_d_source"}, d_source, v.source);
    chk({tag, "_d_denied"}, d_denied, v.exp_den);
    chk({tag, "_d_corrupt"}, d_corrupt, v.exp_den && v.exp_dop == 3'd1);
    chk({tag, "_d_data"}, d_data, v.exp_data);
    chk({tag, "_a_ready_resp"}, a_ready, 1'b0);
  endtask

  // Called and returns at a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input bit noise);
    int reqcyc;
    bit done;
    a_valid = 1'b1; a_opcode = v.opcode; a_param = 3'd0; a_size = v.size;
    a_source = v.source; a_address = v.addr; a_mask = v.mask; a_data = v.data;
    chk("a_ready_idle", a_ready, 1'b1);
    @(posedge clock); @(negedge clock);
    a_valid = 1'b0;
    if (noise) begin
      a_opcode = 3'($urandom); a_size = 3'($urandom); a_address = $urandom;
      a_mask = 4'($urandom); a_data = $urandom; a_source = 2'($urandom);
    end
    reqcyc = 0;
    done = 0;
    for (int k = 0; k < TIMEOUT + 3 && !done; k++) begin
      reg_ack = 1'b0;
      if (reg_req) begin
        chk("reg_we", reg_we, v.opcode != 3'd4);
        chk("reg_addr", reg_addr, v.addr & 32'hFFFF_FFFC);
        chk("reg_be", reg_be, (v.opcode == 3'd4) ? 4'hF : v.mask);
        chk("reg_wdata", reg_wdata, v.data);
        if (k == v.ack_delay) begin
          reg_ack = 1'b1; reg_rdata = v.rdata; reg_err = v.err;
        end else if (noise) begin
          reg_rdata = $urandom; reg_err = 1'($urandom);
        end
        reqcyc++;
        @(posedge clock); @(negedge clock);
      end else begin
        done = 1;
      end
    end
    reg_ack = 1'b0;
    chk("reg_req_cycles", reqcyc, v.exp_reqcyc);
    for (int i = 0; i <= v.dr_delay; i++) begin
      check_d(v, "resp");
      if (i < v.dr_delay) begin
        d_ready = 1'b0;
        if (noise) begin
          reg_ack = 1'($urandom); reg_rdata = $urandom; reg_err = 1'($urandom);
        end
        @(posedge clock); @(negedge clock);
      end
    end
    reg_ack = 1'b0;
    d_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    d_ready = 1'b0;
    chk("d_valid_after", d_valid, 1'b0);
    chk("a_ready_after", a_ready, 1'b1);
    $display("txn op=%0d size=%0d src=%0d addr=%h ack_delay=%0d dr_delay=%0d -> reqcyc=%0d denied=%0b data=%h",
             v.opcode, v.size, v.source, v.addr, v.ack_delay, v.dr_delay,
             reqcyc, d_denied, v.exp_data);
  endtask

  vec_t vecs[11];
  vec_t rv;
  logic [2:0] op_pool [10];

  initial begin
    vecs[0]  = '{3'd4, 3'd2, 2'd2, 32'h10,  4'hF, 32'h0,        0, 32'hDEADBEEF, 1'b0, 0, 3'd1, 1'b0, 32'hDEADBEEF, 1};
    vecs[1]  = '{3'd1, 3'd0, 2'd1, 32'h13,  4'h8, 32'hAA000000, 1, 32'h12345678, 1'b0, 0, 3'd0, 1'b0, 32'h0,        2};
    vecs[2]  = '{3'd4, 3'd3, 2'd0, 32'h0,   4'hF, 32'h0,        0, 32'h11111111, 1'b0, 0, 3'd1, 1'b1, 32'h0,        0};
    vecs[3]  = '{3'd4, 3'd2, 2'd3, 32'h2,   4'hF, 32'h0,        0, 32'h22222222, 1'b0, 1, 3'd1, 1'b1, 32'h0,        0};
    vecs[4]  = '{3'd0, 3'd2, 2'd1, 32'h20,  4'hF, 32'h01020304, -1, 32'h0,       1'b0, 0, 3'd0, 1'b1, 32'h0,        4};
    vecs[5]  = '{3'd4, 3'd2, 2'd3, 32'h44,  4'hF, 32'h0,        2, 32'hCAFEF00D, 1'b0, 5, 3'd1, 1'b0, 32'hCAFEF00D, 3};
    vecs[6]  = '{3'd4, 3'd1, 2'd0, 32'h6,   4'h3, 32'h0,        3, 32'h000055AA, 1'b0, 0, 3'd1, 1'b0, 32'h000055AA, 4};
    vecs[7]  = '{3'd4, 3'd2, 2'd2, 32'h8,   4'hF, 32'h0,        0, 32'h00000011, 1'b1, 0, 3'd1, 1'b1, 32'h0,        1};
    vecs[8]  = '{3'd6, 3'd2, 2'd1, 32'h0,   4'hF, 32'h0,        0, 32'h33333333, 1'b0, 0, 3'd0, 1'b1, 32'h0,        0};
    vecs[9]  = '{3'd0, 3'd2, 2'd0, 32'h100, 4'hF, 32'h5A5A5A5A, 0, 32'h0,        1'b1, 2, 3'd0, 1'b1, 32'h0,        1};
    vecs[10] = '{3'd1, 3'd1, 2'd2, 32'h1,   4'h3, 32'h0000BEEF, 0, 32'h0,        1'b0, 0, 3'd0, 1'b1, 32'h0,        0};
    op_pool = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd0, 3'd1, 3'd4, 3'd2, 3'd3, 3'd7};

    reset_n = 1'b0; d_ready = 1'b0; reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd4; a_param = 3'd0; a_size = 3'd2; a_source = 2'd3;
    a_address = 32'hFFFF_FFF0; a_mask = 4'hF; a_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_reg_req", reg_req, 1'b0);
    chk("rst_reg_we", reg_we, 1'b0);
    chk("rst_reg_addr", reg_addr, 32'h0);
    chk("rst_reg_be", reg_be, 4'h0);
    chk("rst_reg_wdata", reg_wdata, 32'h0);
    chk("rst_d_fields", {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt}, 0);
    chk("rst_d_data", d_data, 32'h0);
    a_valid = 1'b0;
    reset_n = 1'b1;
    #1 chk("rel_a_ready_before_edge", a_ready, 1'b0);
    @(negedge clock);
    chk("rel_a_ready_first_edge", a_ready, 1'b1);

    for (int i = 0; i < 11; i++) run_txn(vecs[i], 1'b0);

    // Reset pulsed while the register side is being accessed.
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_source = 2'd1;
    a_address = 32'h80; a_mask = 4'hF; a_data = 32'h0;
    @(posedge clock); @(negedge clock);
    a_valid = 1'b0;
    chk("mid_reg_req_access", reg_req, 1'b1);
    reset_n = 1'b0;
    reg_ack = 1'b1; reg_rdata = 32'h77777777;
    #1;
    chk("mid_reg_req_drop", reg_req, 1'b0);
    chk("mid_d_valid_drop", d_valid, 1'b0);
    chk("mid_a_ready_in_reset", a_ready, 1'b0);
    repeat (2) @(negedge clock);
    reg_ack = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_a_ready_release", a_ready, 1'b1);
    chk("mid_no_d_response", d_valid, 1'b0);
    run_txn(vecs[0], 1'b0);

    for (int n = 0; n < 60; n++) begin
      rv = vecs[0];
      rv.opcode = op_pool[$urandom_range(0, 9)];
      rv.size = ($urandom_range(0, 5) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      rv.source = 2'($urandom);
      rv.addr = $urandom;
      if ($urandom_range(0, 3) != 0 && rv.size <= 2)
        rv.addr = rv.addr & ~((32'd1 << rv.size) - 32'd1);
      rv.mask = 4'($urandom);
      rv.data = $urandom;
      rv.ack_delay = int'($urandom_range(0, 6)) - 1;
      rv.rdata = $urandom;
      rv.err = ($urandom_range(0, 4) == 0);
      rv.dr_delay = $urandom_range(0, 3);
      run_txn(model(rv), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
